// File: rtl/dmem_pkg.sv
// Shared types and helpers for the handshaked data memory and its load-extension logic.
package dmem_pkg;

    typedef enum logic [2:0] {
        SZ_B  = 3'b000,
        SZ_H  = 3'b001,
        SZ_W  = 3'b010,
        SZ_BU = 3'b100,
        SZ_HU = 3'b101
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Unsigned sizes only make sense for loads; everything else outside B/H/W is illegal.
    function automatic logic is_legal_size(input logic [2:0] size, input logic we);
        case (size)
            SZ_B, SZ_H, SZ_W: return 1'b1;
            SZ_BU, SZ_HU:     return !we;
            default:          return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] size_bytes(input logic [2:0] size);
        case (size)
            SZ_H, SZ_HU: return 3'd2;
            SZ_W:        return 3'd4;
            default:     return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_load_ext.sv
// Combinational load extension: selects byte/half/word from a raw little-endian word
// and sign- or zero-extends it to 32 bits. Shared with the core's forwarding path.
module dmem_load_ext
    import dmem_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [2:0]  size,
    output logic [31:0] result
);

    always_comb begin
        result = 32'h0;
        case (size)
            SZ_B:    result = {{24{raw[7]}}, raw[7:0]};
            SZ_BU:   result = {24'h0, raw[7:0]};
            SZ_H:    result = {{16{raw[15]}}, raw[15:0]};
            SZ_HU:   result = {16'h0, raw[15:0]};
            SZ_W:    result = raw;
            default: result = 32'h0;
        endcase
    end

endmodule

// File: rtl/dmem_hs_ctrl.sv
// Byte-addressable little-endian data memory with request/response handshakes and
// programmable latency. Define DMEM_MISALIGN_ERR_EN to reject misaligned H/W accesses.
module dmem_hs_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = 32,
    parameter int LATENCY = 1
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [2:0]        req_size,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output state_e            state_dbg
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    // Handshakes: a transfer happens on a rising edge where valid && ready. The request
    // side is ready only in IDLE; a response stays valid with stable data until taken.
    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic             we_q;
    logic [AW-1:0]    addr_q;
    logic [31:0]      wdata_q;
    logic [2:0]       size_q;
    logic [7:0]       mem [DEPTH];

    logic [AW-1:0] a0, a1, a2, a3;
    logic [31:0]   raw_word;
    logic [31:0]   load_data;
    logic [2:0]    nbytes;
    logic          acc_err;

    // Byte lanes wrap naturally in AW-bit arithmetic, giving modulo-DEPTH addressing.
    assign a0 = addr_q;
    assign a1 = addr_q + AW'(1);
    assign a2 = addr_q + AW'(2);
    assign a3 = addr_q + AW'(3);

    assign raw_word  = {mem[a3], mem[a2], mem[a1], mem[a0]};
    assign nbytes    = size_bytes(size_q);
    assign state_dbg = state;

    always_comb begin
        acc_err = !is_legal_size(size_q, we_q);
`ifdef DMEM_MISALIGN_ERR_EN
        if ((size_q == SZ_H || size_q == SZ_HU) && addr_q[0])
            acc_err = 1'b1;
        if (size_q == SZ_W && addr_q[1:0] != 2'b00)
            acc_err = 1'b1;
`else
        acc_err = acc_err;
`endif
    end

    dmem_load_ext u_load_ext (
        .raw    (raw_word),
        .size   (size_q),
        .result (load_data)
    );

    generate
        if (ADDR_W > AW) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^req_addr[ADDR_W-1:AW];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            cnt       <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= 32'h0;
            size_q    <= 3'b000;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        we_q      <= req_we;
                        addr_q    <= req_addr[AW-1:0];
                        wdata_q   <= req_wdata;
                        size_q    <= req_size;
                        cnt       <= CNT_INIT;
                        req_ready <= 1'b0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= acc_err;
                        rsp_rdata <= (acc_err || we_q) ? 32'h0 : load_data;
                        state     <= RESP;
                        if (we_q && !acc_err) begin
                            mem[a0] <= wdata_q[7:0];
                            if (nbytes >= 3'd2)
                                mem[a1] <= wdata_q[15:8];
                            if (nbytes == 3'd4) begin
                                mem[a2] <= wdata_q[23:16];
                                mem[a3] <= wdata_q[31:24];
                            end
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
